// File: rtl/sme_string_matcher.sv
// sme_string_matcher -- String Matching Engine.
//   Stores a text string (up to STR_MAX chars), then searches it for serially
//   delivered patterns (up to PAT_MAX chars) and reports the leftmost match.
//   Pattern specials: '.' any char, '^' word-start anchor, '$' word-end anchor.
//   Optional feature macro: SME_STAR_WILDCARD_EN enables the single '*' wildcard;
//   without it '*' is an ordinary literal byte.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   chardata     in   [7:0] character byte
//   isstring     in   chardata is a string char
//   ispattern    in   chardata is a pattern char
//   valid        out  one-cycle result strobe
//   match        out  pattern found (held after valid)
//   match_index  out  [4:0] start of leftmost match, 0 when no match (held)
module sme_string_matcher #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 chardata,
   input  logic                       isstring,
   input  logic                       ispattern,
   output logic                       valid,
   output logic                       match,
   output logic [$clog2(STR_MAX)-1:0] match_index
);

   localparam int IW  = $clog2(STR_MAX);
   localparam int LW  = $clog2(STR_MAX + 1);
   localparam int PW  = $clog2(PAT_MAX);
   localparam int PLW = $clog2(PAT_MAX + 1);

   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_SPACE  = 8'h20;
`ifdef SME_STAR_WILDCARD_EN
   localparam logic [7:0] CH_STAR   = 8'h2A;
`endif

   typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, MATCH, OUT} state_t;
   state_t state, state_nx;

   logic [7:0]     str_mem [STR_MAX];
   logic [7:0]     pat_mem [PAT_MAX];
   logic [LW-1:0]  str_len;
   logic [PLW-1:0] pat_len;

   // search state: s = current start (or tail start), pos = string cursor,
   // p = pattern cursor, last_tail = rightmost tail match position
   logic [LW-1:0]  s, pos, last_tail;
   logic [PLW-1:0] p;
   logic           tail_phase;

   logic           str_we, pat_we;
   logic [IW-1:0]  str_wa;
   logic [PW-1:0]  pat_wa;

   logic           has_star;
   logic [PLW-1:0] star_pos, seg_end;
   logic [7:0]     pc, cur, prv;
   logic [IW-1:0]  pos_lo;
   logic           in_str, ok, consume;
   logic           done, hit, advance, next_start, enter_head;
   logic           pat_end;

   // ---------------- character storage ----------------
   always_comb begin
      str_we = 1'b0;
      str_wa = '0;
      pat_we = 1'b0;
      pat_wa = '0;
      case (state)
         IDLE: begin
            str_we = isstring;
            pat_we = !isstring && ispattern;
         end
         LOAD_STR: begin
            str_we = isstring && (str_len < LW'(STR_MAX));
            str_wa = str_len[IW-1:0];
            pat_we = !isstring && ispattern;
         end
         LOAD_PAT: begin
            pat_we = ispattern && (pat_len < PLW'(PAT_MAX));
            pat_wa = pat_len[PW-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (str_we) str_mem[str_wa] <= chardata;
      if (pat_we) pat_mem[pat_wa] <= chardata;
   end

   // ---------------- wildcard location ----------------
   always_comb begin
      has_star = 1'b0;
      star_pos = pat_len;
`ifdef SME_STAR_WILDCARD_EN
      for (int unsigned i = 0; i < PAT_MAX; i++) begin
         if (!has_star && (PLW'(i) < pat_len) && (pat_mem[PW'(i)] == CH_STAR)) begin
            has_star = 1'b1;
            star_pos = PLW'(i);
         end
      end
`endif
   end

   // ---------------- single pattern-char evaluation ----------------
   always_comb begin
      pc      = pat_mem[p[PW-1:0]];
      pos_lo  = pos[IW-1:0];
      cur     = str_mem[pos_lo];
      prv     = str_mem[pos_lo - IW'(1)];
      in_str  = pos < str_len;
      ok      = 1'b0;
      consume = 1'b1;
      case (pc)
         CH_CARET: begin
            ok      = (pos == '0) || (prv == CH_SPACE);
            consume = 1'b0;
         end
         CH_DOLLAR: begin
            ok      = !in_str || (cur == CH_SPACE);
            consume = 1'b0;
         end
         CH_DOT:  ok = in_str;
         default: ok = in_str && (cur == pc);
      endcase
   end

   // With a wildcard, the tail is scanned first from the string end downwards
   // to find its rightmost match; a head match at s then succeeds iff it ends
   // at or before that position. This keeps the search linear in the string.
   always_comb begin
      seg_end    = tail_phase ? pat_len : star_pos;
      done       = 1'b0;
      hit        = 1'b0;
      advance    = 1'b0;
      next_start = 1'b0;
      enter_head = 1'b0;
      if (!tail_phase && (s >= str_len)) begin
         done = 1'b1;
      end else if (p == seg_end) begin
         if (tail_phase) begin
            enter_head = 1'b1;
         end else if (!has_star || (pos <= last_tail)) begin
            done = 1'b1;
            hit  = 1'b1;
         end else begin
            next_start = 1'b1;
         end
      end else if (ok) begin
         advance = 1'b1;
      end else begin
         next_start = 1'b1;
      end
      if (next_start && tail_phase && (s == '0)) done = 1'b1;
   end

   assign pat_end = (state == LOAD_PAT) && !ispattern;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (isstring)       state_nx = LOAD_STR;
            else if (ispattern) state_nx = LOAD_PAT;
         end
         LOAD_STR: begin
            if (!isstring) state_nx = ispattern ? LOAD_PAT : IDLE;
         end
         LOAD_PAT: if (!ispattern) state_nx = MATCH;
         MATCH:    if (done) state_nx = OUT;
         OUT:      state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // ---------------- lengths, search registers, outputs ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         str_len     <= '0;
         pat_len     <= '0;
         s           <= '0;
         pos         <= '0;
         p           <= '0;
         last_tail   <= '0;
         tail_phase  <= 1'b0;
         valid       <= 1'b0;
         match       <= 1'b0;
         match_index <= '0;
      end else begin
         valid <= 1'b0;
         if (state == IDLE && isstring) str_len <= LW'(1);
         else if (str_we)               str_len <= str_len + LW'(1);
         if (pat_we) pat_len <= (state == LOAD_PAT) ? pat_len + PLW'(1) : PLW'(1);

         if (pat_end) begin
            tail_phase <= has_star;
            if (has_star) begin
               s   <= str_len;
               pos <= str_len;
               p   <= star_pos + PLW'(1);
            end else begin
               s   <= '0;
               pos <= '0;
               p   <= '0;
            end
         end

         if (state == MATCH) begin
            if (done) begin
               valid       <= 1'b1;
               match       <= hit;
               match_index <= hit ? s[IW-1:0] : '0;
            end else if (enter_head) begin
               last_tail  <= s;
               tail_phase <= 1'b0;
               s          <= '0;
               pos        <= '0;
               p          <= '0;
            end else if (advance) begin
               p   <= p + PLW'(1);
               pos <= pos + LW'(consume);
            end else if (next_start) begin
               if (tail_phase) begin
                  s   <= s - LW'(1);
                  pos <= s - LW'(1);
                  p   <= star_pos + PLW'(1);
               end else begin
                  s   <= s + LW'(1);
                  pos <= s + LW'(1);
                  p   <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sme_string_matcher.sv
// tb_sme_string_matcher -- directed bench for sme_string_matcher.
//   A reference search model computes each expected result from the matching
//   rules; one compare process checks every valid strobe, the output hold
//   behaviour on all other cycles, and pins the model to literal results.
//   Define SME_STAR_WILDCARD_EN for both bench and design to test '*'.
module tb_sme_string_matcher;

   logic       clk = 1'b0;
   logic       reset, isstring, ispattern;
   logic [7:0] chardata;
   logic       valid, match;
   logic [4:0] match_index;

`ifdef SME_STAR_WILDCARD_EN
   localparam bit STAR_EN = 1'b1;
`else
   localparam bit STAR_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   sme_string_matcher #(.STR_MAX(32), .PAT_MAX(8)) dut (
      .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
      .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index)
   );

   int    tests = 0, fails = 0;
   int    pend_id = 0, done_id = 0;
   bit    exp_m;
   int    exp_idx;
   bit    hold_m;
   int    hold_idx;
   int    wait_cnt;
   string cur_str;

   // ---------------- reference model ----------------
   function automatic bit seg_at(input string st, input string pt, input int p0,
                                 input int p1, input int pos_in, output int e);
      int  pos = pos_in;
      byte c;
      e = 0;
      for (int p = p0; p < p1; p++) begin
         c = pt[p];
         if (c == 8'h5E) begin
            if (!(pos == 0 || st[pos-1] == 8'h20)) return 1'b0;
         end else if (c == 8'h24) begin
            if (!(pos == st.len() || st[pos] == 8'h20)) return 1'b0;
         end else if (c == 8'h2E) begin
            if (pos >= st.len()) return 1'b0;
            pos++;
         end else begin
            if (pos >= st.len() || st[pos] != c) return 1'b0;
            pos++;
         end
      end
      e = pos;
      return 1'b1;
   endfunction

   function automatic void model(input string st_in, input string pt_in, input bit star_en,
                                 output bit m, output int idx);
      string st = (st_in.len() > 32) ? st_in.substr(0, 31) : st_in;
      string pt = (pt_in.len() > 8) ? pt_in.substr(0, 7) : pt_in;
      int    sp = -1;
      int    e, e2;
      m = 1'b0;
      idx = 0;
      if (star_en)
         for (int i = 0; i < pt.len(); i++)
            if (sp < 0 && pt[i] == 8'h2A) sp = i;
      for (int s = 0; s < st.len(); s++) begin
         if (sp < 0) begin
            if (seg_at(st, pt, 0, pt.len(), s, e)) begin
               m = 1'b1; idx = s; return;
            end
         end else if (seg_at(st, pt, 0, sp, s, e)) begin
            for (int t = e; t <= st.len(); t++)
               if (seg_at(st, pt, sp + 1, pt.len(), t, e2)) begin
                  m = 1'b1; idx = s; return;
               end
         end
      end
   endfunction

   // ---------------- compare process ----------------
   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic pin(input string st, input string pt, input bit req_m, input int req_idx);
      bit m;
      int ix;
      model(st, pt, STAR_EN, m, ix);
      check({"model ", pt, " match"}, int'(m), int'(req_m));
      check({"model ", pt, " index"}, ix, req_idx);
   endtask

   initial begin
      hold_m = 1'b0;
      hold_idx = 0;
      wait_cnt = 0;
      pin("hello world", "wor", 1'b1, 6);
      pin("hello world", "^orl", 1'b0, 0);
      pin("hello world", "lo$", 1'b1, 3);
      pin("hello world", "o.w", 1'b1, 4);
      pin("abc abc", "c$", 1'b1, 2);
`ifdef SME_STAR_WILDCARD_EN
      pin("hello world", "h*d", 1'b1, 0);
      pin("hello world", "o*r", 1'b1, 4);
      pin("hello world", "w*h", 1'b0, 0);
`else
      pin("hello world", "h*d", 1'b0, 0);
`endif
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_m = 1'b0;
            hold_idx = 0;
         end else if (valid) begin
            if (pend_id != done_id) begin
               check("result match", int'(match), int'(exp_m));
               check("result index", int'(match_index), exp_idx);
               hold_m = exp_m;
               hold_idx = exp_idx;
               done_id = pend_id;
               wait_cnt = 0;
            end else begin
               check("unexpected valid", int'(valid), 0);
            end
         end else begin
            check("hold match", int'(match), int'(hold_m));
            check("hold index", int'(match_index), hold_idx);
            if (pend_id != done_id) begin
               wait_cnt++;
               if (wait_cnt > 450) begin
                  tests++;
                  fails++;
                  $display("FAIL valid timeout: waited %0d cycles, limit 450", wait_cnt);
                  done_id = pend_id;
                  wait_cnt = 0;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_str(input string st);
      for (int i = 0; i < st.len(); i++) begin
         @(posedge clk); #1;
         chardata = st[i];
         isstring = 1'b1;
      end
      @(posedge clk); #1;
      isstring = 1'b0;
      chardata = 8'h00;
      cur_str = st;
   endtask

   task automatic send_pat(input string pt);
      bit m;
      int ix;
      for (int i = 0; i < pt.len(); i++) begin
         @(posedge clk); #1;
         chardata = pt[i];
         ispattern = 1'b1;
      end
      @(posedge clk); #1;
      ispattern = 1'b0;
      chardata = 8'h00;
      model(cur_str, pt, STAR_EN, m, ix);
      exp_m = m;
      exp_idx = ix;
      pend_id++;
      while (done_id != pend_id) @(posedge clk);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      reset = 1'b1;
      isstring = 1'b0;
      ispattern = 1'b0;
      chardata = 8'h00;
      cur_str = "";
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);

      send_str("hello world");
      send_pat("wor");
      send_pat("^wor");
      send_pat("^orl");
      send_pat("ld$");
      send_pat("lo$");
      send_pat("h.l");
      send_pat("o.w");
      send_pat("xyz");
      send_pat("h*d");
      send_pat("o*r");
      send_pat("w*h");
      send_pat("$");
      send_pat("^");
      send_pat("hello worXX");

      send_str("2*3=6 ok");
      send_pat("2*3");
      send_pat("*=");

      send_str("abcdefghijklmnopqrstuvwxyz0123456789");
      send_pat("345");
      send_pat("567");
      send_pat("5$");

      send_str("abc abc");
      send_pat("c$");
      send_pat("^abc$");

      // abort a pattern load with reset: no strobe, outputs and lengths clear
      @(posedge clk); #1;
      chardata = "a";
      ispattern = 1'b1;
      @(posedge clk); #1;
      chardata = "b";
      @(posedge clk); #1;
      reset = 1'b1;
      ispattern = 1'b0;
      cur_str = "";
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) @(posedge clk);
      send_pat("a");

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
